sys_ctrl_rx_decoder: RTL and testbench

//  Destination-domain command-frame decoder fed by the byte synchronizer's sync_data/sync_en outputs.

---
 rtl/sys_ctrl_rx_decoder.sv | 191 +++++++++++++++++++
 tb/tb_sys_ctrl_rx_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_rx_decoder
// Brief    : Decodes synchronized UART command frames into one-cycle register
//            file write/read strobes and ALU start strobes in the reference
//            clock domain.
//            Frames: AA addr data   -> RF write
//                    BB addr        -> RF read
//                    CC opA opB fun -> RF[0]=opA, RF[1]=opB, ALU start
//                    DD fun         -> ALU start
// Options  : FRAME_TIMEOUT_EN - abort a partial frame after TIMEOUT_CYCLES
//            idle cycles and pulse o_frame_timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl_rx_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rf_wr_en,
    output logic                  o_rf_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    output logic [DATA_WIDTH-1:0] o_rf_wr_data,
    output logic                  o_alu_en,
    output logic [FUN_WIDTH-1:0]  o_alu_fun,
    output logic                  o_clk_gate_en,
    output logic                  o_cmd_err,
    output logic                  o_frame_timeout
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_ADDR = 3'd1;
    localparam logic [2:0] c_WR_DATA = 3'd2;
    localparam logic [2:0] c_RD_ADDR = 3'd3;
    localparam logic [2:0] c_OPA     = 3'd4;
    localparam logic [2:0] c_OPB     = 3'd5;
    localparam logic [2:0] c_ALU_FUN = 3'd6;

    localparam logic [DATA_WIDTH-1:0] c_CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_OPS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU = DATA_WIDTH'(8'hDD);

    // A zero timeout would abort every frame the cycle it starts.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr_lat;
    logic                  r_rf_wr_en;
    logic                  r_rf_rd_en;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [DATA_WIDTH-1:0] r_rf_wr_data;
    logic                  r_alu_en;
    logic [FUN_WIDTH-1:0]  r_alu_fun;
    logic                  r_clk_gate_en;
    logic                  r_cmd_err;
    logic                  r_frame_timeout;
    logic                  w_timeout;

`ifdef FRAME_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Abort fires on the edge where the idle count reaches TIMEOUT_CYCLES;
    // an incoming byte on that edge takes priority.
    assign w_timeout = !i_rx_valid && (r_state != c_IDLE) && (r_cnt == c_CNT_LAST);

    // Idle-cycle counter for the current partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_rx_valid || (r_state == c_IDLE) || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Frame FSM plus registered strobes and held address/data/function.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_IDLE;
            r_addr_lat      <= '0;
            r_rf_wr_en      <= 1'b0;
            r_rf_rd_en      <= 1'b0;
            r_rf_addr       <= '0;
            r_rf_wr_data    <= '0;
            r_alu_en        <= 1'b0;
            r_alu_fun       <= '0;
            r_clk_gate_en   <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_frame_timeout <= 1'b0;
        end else begin
            r_rf_wr_en      <= 1'b0;
            r_rf_rd_en      <= 1'b0;
            r_alu_en        <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_frame_timeout <= 1'b0;

            // Gate drops the cycle after the ALU start; a new CC/DD on this
            // same edge re-arms it below.
            if (r_alu_en) begin
                r_clk_gate_en <= 1'b0;
            end

            if (i_rx_valid) begin
                case (r_state)
                    c_IDLE: begin
                        if (i_rx_data == c_CMD_WR) begin
                            r_state <= c_WR_ADDR;
                        end else if (i_rx_data == c_CMD_RD) begin
                            r_state <= c_RD_ADDR;
                        end else if (i_rx_data == c_CMD_OPS) begin
                            r_state       <= c_OPA;
                            r_clk_gate_en <= 1'b1;
                        end else if (i_rx_data == c_CMD_ALU) begin
                            r_state       <= c_ALU_FUN;
                            r_clk_gate_en <= 1'b1;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    c_WR_ADDR: begin
                        // Held privately so o_rf_addr only changes with a strobe.
                        r_addr_lat <= i_rx_data[ADDR_WIDTH-1:0];
                        r_state    <= c_WR_DATA;
                    end
                    c_WR_DATA: begin
                        r_rf_addr    <= r_addr_lat;
                        r_rf_wr_data <= i_rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= c_IDLE;
                    end
                    c_RD_ADDR: begin
                        r_rf_addr  <= i_rx_data[ADDR_WIDTH-1:0];
                        r_rf_rd_en <= 1'b1;
                        r_state    <= c_IDLE;
                    end
                    c_OPA: begin
                        r_rf_addr    <= ADDR_WIDTH'(0);
                        r_rf_wr_data <= i_rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= c_OPB;
                    end
                    c_OPB: begin
                        r_rf_addr    <= ADDR_WIDTH'(1);
                        r_rf_wr_data <= i_rx_data;
                        r_rf_wr_en   <= 1'b1;
                        r_state      <= c_ALU_FUN;
                    end
                    c_ALU_FUN: begin
                        r_alu_fun <= i_rx_data[FUN_WIDTH-1:0];
                        r_alu_en  <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_state         <= c_IDLE;
                r_frame_timeout <= 1'b1;
                r_clk_gate_en   <= 1'b0;
            end
        end
    end

    assign o_rf_wr_en      = r_rf_wr_en;
    assign o_rf_rd_en      = r_rf_rd_en;
    assign o_rf_addr       = r_rf_addr;
    assign o_rf_wr_data    = r_rf_wr_data;
    assign o_alu_en        = r_alu_en;
    assign o_alu_fun       = r_alu_fun;
    assign o_clk_gate_en   = r_clk_gate_en;
    assign o_cmd_err       = r_cmd_err;
    assign o_frame_timeout = r_frame_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_ctrl_rx_decoder
// Brief    : Self-checking bench for sys_ctrl_rx_decoder. Each scenario
//            queues stimulus together with the expected output snapshot for
//            the cycle after that stimulus, then pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl_rx_decoder;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       alu;
        logic       err;
        logic       to;
        logic       gate;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] fun;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rf_wr_en, o_rf_rd_en, o_alu_en, o_clk_gate_en;
    logic       o_cmd_err, o_frame_timeout;
    logic [3:0] o_rf_addr, o_alu_fun;
    logic [7:0] o_rf_wr_data;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [8:0] stim_q[$];
    obs_t       sb_q[$];

    always #5 clk = ~clk;

    sys_ctrl_rx_decoder #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .FUN_WIDTH     (4),
        .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rf_wr_en     (o_rf_wr_en),
        .o_rf_rd_en     (o_rf_rd_en),
        .o_rf_addr      (o_rf_addr),
        .o_rf_wr_data   (o_rf_wr_data),
        .o_alu_en       (o_alu_en),
        .o_alu_fun      (o_alu_fun),
        .o_clk_gate_en  (o_clk_gate_en),
        .o_cmd_err      (o_cmd_err),
        .o_frame_timeout(o_frame_timeout)
    );

    function automatic obs_t sample();
        return '{o_rf_wr_en, o_rf_rd_en, o_alu_en, o_cmd_err, o_frame_timeout,
                 o_clk_gate_en, o_rf_addr, o_rf_wr_data, o_alu_fun};
    endfunction

    function automatic obs_t o(logic wr, logic rd, logic alu, logic err, logic to,
                               logic gate, logic [3:0] a, logic [7:0] d, logic [3:0] f);
        return '{wr, rd, alu, err, to, gate, a, d, f};
    endfunction

    // Valid byte / idle cycle stimulus words.
    function automatic logic [8:0] V(logic [7:0] b);
        return {1'b1, b};
    endfunction
    localparam logic [8:0] I = 9'h000;

    task automatic add(input logic [8:0] s, input obs_t e);
        stim_q.push_back(s);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got !== o(0,0,0,0,0,0,4'h0,8'h00,4'h0)) begin
            n_errors++;
            $display("FAIL reset: got %h expected %h", got, o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        end
        i_rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        obs_t got, e;
        logic [8:0] s;
        add(V(8'hAA), o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        add(I,        o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        add(V(8'h05), o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        add(V(8'h3C), o(1,0,0,0,0,0,4'h5,8'h3C,4'h0));
        add(I,        o(0,0,0,0,0,0,4'h5,8'h3C,4'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL write step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_read();
        obs_t got, e;
        logic [8:0] s;
        add(V(8'hBB), o(0,0,0,0,0,0,4'h5,8'h3C,4'h0));
        add(V(8'h0F), o(0,1,0,0,0,0,4'hF,8'h3C,4'h0));
        add(I,        o(0,0,0,0,0,0,4'hF,8'h3C,4'h0));
        add(V(8'hBB), o(0,0,0,0,0,0,4'hF,8'h3C,4'h0));
        add(I,        o(0,0,0,0,0,0,4'hF,8'h3C,4'h0));
        add(V(8'hA7), o(0,1,0,0,0,0,4'h7,8'h3C,4'h0));
        add(I,        o(0,0,0,0,0,0,4'h7,8'h3C,4'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL read step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_alu_frame();
        obs_t got, e;
        logic [8:0] s;
        add(V(8'hCC), o(0,0,0,0,0,1,4'h7,8'h3C,4'h0));
        add(I,        o(0,0,0,0,0,1,4'h7,8'h3C,4'h0));
        add(V(8'h12), o(1,0,0,0,0,1,4'h0,8'h12,4'h0));
        add(V(8'h34), o(1,0,0,0,0,1,4'h1,8'h34,4'h0));
        add(I,        o(0,0,0,0,0,1,4'h1,8'h34,4'h0));
        add(V(8'h01), o(0,0,1,0,0,1,4'h1,8'h34,4'h1));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h34,4'h1));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h34,4'h1));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL alu_frame step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_cmd_err();
        obs_t got, e;
        logic [8:0] s;
        add(V(8'h7E), o(0,0,0,1,0,0,4'h1,8'h34,4'h1));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h34,4'h1));
        add(V(8'hDD), o(0,0,0,0,0,1,4'h1,8'h34,4'h1));
        add(V(8'hF3), o(0,0,1,0,0,1,4'h1,8'h34,4'h3));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h34,4'h3));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL cmd_err step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        obs_t got, e;
        logic [8:0] s;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hAA;
        @(posedge clk);
        i_rx_data  = 8'h05;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        got = sample();
        n_checks++;
        if (got !== o(0,0,0,0,0,0,4'h0,8'h00,4'h0)) begin
            n_errors++;
            $display("FAIL reset_midframe clear: got %h expected %h", got, o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        end
        @(negedge clk);
        rst = 1'b1;
        add(V(8'hAA), o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        add(V(8'h02), o(0,0,0,0,0,0,4'h0,8'h00,4'h0));
        add(V(8'h99), o(1,0,0,0,0,0,4'h2,8'h99,4'h0));
        add(I,        o(0,0,0,0,0,0,4'h2,8'h99,4'h0));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL reset_midframe step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        logic [8:0] s;
        add(V(8'hAA), o(0,0,0,0,0,0,4'h2,8'h99,4'h0));
        add(V(8'h03), o(0,0,0,0,0,0,4'h2,8'h99,4'h0));
        add(V(8'h44), o(1,0,0,0,0,0,4'h3,8'h44,4'h0));
        add(V(8'hBB), o(0,0,0,0,0,0,4'h3,8'h44,4'h0));
        add(V(8'h09), o(0,1,0,0,0,0,4'h9,8'h44,4'h0));
        add(V(8'hDD), o(0,0,0,0,0,1,4'h9,8'h44,4'h0));
        add(V(8'h05), o(0,0,1,0,0,1,4'h9,8'h44,4'h5));
        add(V(8'hCC), o(0,0,0,0,0,1,4'h9,8'h44,4'h5));
        add(V(8'h11), o(1,0,0,0,0,1,4'h0,8'h11,4'h5));
        add(V(8'h22), o(1,0,0,0,0,1,4'h1,8'h22,4'h5));
        add(V(8'h0A), o(0,0,1,0,0,1,4'h1,8'h22,4'hA));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t got, e;
        logic [8:0] s;
`ifdef FRAME_TIMEOUT_EN
        // Silence after AA aborts on the 8th idle cycle.
        add(V(8'hAA), o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        for (int k = 0; k < 7; k++) add(I, o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(I,        o(0,0,0,0,1,0,4'h1,8'h22,4'hA));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(V(8'h05), o(0,0,0,1,0,0,4'h1,8'h22,4'hA));
        // A byte on the would-be abort cycle is consumed instead.
        add(V(8'hAA), o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        for (int k = 0; k < 7; k++) add(I, o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(V(8'h05), o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(I,        o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(V(8'h3C), o(1,0,0,0,0,0,4'h5,8'h3C,4'hA));
        // Abort of an ALU frame also drops the clock gate.
        add(V(8'hCC), o(0,0,0,0,0,1,4'h5,8'h3C,4'hA));
        for (int k = 0; k < 7; k++) add(I, o(0,0,0,0,0,1,4'h5,8'h3C,4'hA));
        add(I,        o(0,0,0,0,1,0,4'h5,8'h3C,4'hA));
        add(I,        o(0,0,0,0,0,0,4'h5,8'h3C,4'hA));
`else
        // Without the timeout a frame waits indefinitely.
        add(V(8'hAA), o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        for (int k = 0; k < 20; k++) add(I, o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(V(8'h05), o(0,0,0,0,0,0,4'h1,8'h22,4'hA));
        add(V(8'h3C), o(1,0,0,0,0,0,4'h5,8'h3C,4'hA));
        add(I,        o(0,0,0,0,0,0,4'h5,8'h3C,4'hA));
`endif
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            {i_rx_valid, i_rx_data} = s;
            @(posedge clk);
            #1;
            got = sample();
            e = sb_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL timeout step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_frame();
        test_cmd_err();
        test_reset_midframe();
        test_back_to_back();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
